dsamp_sched: RTL

Frame/line scheduler for the 4:1-style downsample datapath: generates the decimation write strobe for the horizontal line FIFO and sequences read bursts out of it. It also produces output frame timing (vsync pulse, href per line) with a runtime-selectable decimation factor. Sits between the camera sync stream and the line FIFO / downstream HDMI scaler, replacing free-running read logic with an explicit state machine.

---
 rtl/dsamp_sched.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dsamp_sched.sv
`default_nettype none
// ============================================================================
// Module   : dsamp_sched
// Purpose  : Frame/line scheduler for the downsample datapath. Decimates the
//            input pixel stream into write strobes for the horizontal line
//            FIFO, then sequences one read burst per output line with output
//            frame timing (vsync pulse, href per line). The decimation factor
//            is sampled once per frame on the rising edge of in_vsync.
// Ports    : dsamp_clk, dsamp_rst_n (async, active low)
//            cfg_factor   - decimation shift 0..3 (1:1 .. 8:1, both axes)
//            in_vsync     - input frame sync, rising edge = frame start
//            in_href      - input line valid, one pixel per cycle
//            fifo_count   - line FIFO occupancy
//            fifo_full    - line FIFO full
//            wr_en        - FIFO write strobe (combinational, pixel-aligned)
//            rd_en        - FIFO read strobe (registered)
//            fifo_flush   - one-cycle FIFO clear on frame abort (registered)
//            out_vsync    - output frame sync (registered)
//            out_href     - output pixel valid, aligned to FIFO read data
//            frame_done   - one-cycle pulse after the last output line
//            ovf_err      - sticky dropped-pixel flag
// Options  : DSAMP_SCHED_OVF_EN - builds the ovf_err detector; when undefined
//            ovf_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module dsamp_sched #(
    parameter int LINE_WIDTH  = 1280,
    parameter int FRAME_LINES = 720,
    parameter int CNT_W       = 12,
    parameter int VS_LEN      = 4,
    parameter int H_GAP       = 8
) (
    input  logic             dsamp_clk,
    input  logic             dsamp_rst_n,
    input  logic [1:0]       cfg_factor,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic             fifo_full,
    output logic             wr_en,
    output logic             rd_en,
    output logic             fifo_flush,
    output logic             out_vsync,
    output logic             out_href,
    output logic             frame_done,
    output logic             ovf_err
);

    localparam logic [CNT_W-1:0] c_line_w   = CNT_W'(LINE_WIDTH);
    localparam logic [CNT_W-1:0] c_frame_h  = CNT_W'(FRAME_LINES);
    localparam logic [CNT_W-1:0] c_vs_last  = CNT_W'(VS_LEN - 1);
    localparam logic [CNT_W-1:0] c_gap_last = CNT_W'(H_GAP - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSYNC = 3'd1,
        ST_WAIT  = 3'd2,
        ST_BURST = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input edge detection
    // ------------------------------------------------------------------
    logic r_vsync_d;
    logic r_href_d;
    logic w_vsync_rise;
    logic w_href_fall;

    assign w_vsync_rise = in_vsync & ~r_vsync_d;
    assign w_href_fall  = ~in_href & r_href_d;

    // ------------------------------------------------------------------
    // Per-frame configuration and input-side pixel position
    // ------------------------------------------------------------------
    logic [1:0]       r_f;
    logic [CNT_W-1:0] r_out_w;
    logic [CNT_W-1:0] r_out_h;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] w_mask;
    logic             w_keep;

    always_ff @(posedge dsamp_clk or negedge dsamp_rst_n) begin
        if (!dsamp_rst_n) begin
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
            r_f       <= 2'd0;
            r_out_w   <= '0;
            r_out_h   <= '0;
            r_col     <= '0;
            r_row     <= '0;
        end else begin
            r_vsync_d <= in_vsync;
            r_href_d  <= in_href;
            if (w_vsync_rise) begin
                // Factor is frozen for the whole frame from this point.
                r_f     <= cfg_factor;
                r_out_w <= c_line_w >> cfg_factor;
                r_out_h <= c_frame_h >> cfg_factor;
                r_col   <= '0;
                r_row   <= '0;
            end else begin
                r_col <= in_href ? (r_col + c_one) : '0;
                if (w_href_fall) begin
                    r_row <= r_row + c_one;
                end
            end
        end
    end

    // Keep the last pixel of every 2^f column group on the first row of
    // every 2^f row group; with f=0 the mask is empty and every pixel is kept.
    assign w_mask = (c_one << r_f) - c_one;
    assign w_keep = ((r_row & w_mask) == '0) && ((r_col & w_mask) == w_mask);
    assign wr_en  = in_href & w_keep & ~fifo_full;

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_line;
    logic [CNT_W-1:0] w_line_nxt;
    logic             w_done_nxt;
    logic             w_abort;

    always_ff @(posedge dsamp_clk or negedge dsamp_rst_n) begin
        if (!dsamp_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_line  <= w_line_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_line_nxt  = r_line;
        w_done_nxt  = 1'b0;
        w_abort     = 1'b0;
        if (w_vsync_rise) begin
            // A new frame start always wins; outside IDLE it aborts the
            // frame in flight and suppresses its frame_done.
            w_state_nxt = ST_VSYNC;
            w_cnt_nxt   = '0;
            w_line_nxt  = '0;
            w_abort     = (r_state != ST_IDLE);
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_VSYNC: begin
                    if (r_cnt == c_vs_last) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
                ST_WAIT: begin
                    if (fifo_count >= r_out_w) begin
                        w_state_nxt = ST_BURST;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_BURST: begin
                    if (r_cnt == (r_out_w - c_one)) begin
                        w_cnt_nxt  = '0;
                        w_line_nxt = r_line + c_one;
                        if ((r_line + c_one) == r_out_h) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_GAP;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. rd_en follows the next-state so it is high in
    // exactly the BURST cycles; out_vsync follows the current state, which
    // places it two cycles after the in_vsync rising edge.
    // ------------------------------------------------------------------
    logic r_rd_en;
    logic r_flush;
    logic r_out_vsync;
    logic r_out_href;
    logic r_frame_done;

    always_ff @(posedge dsamp_clk or negedge dsamp_rst_n) begin
        if (!dsamp_rst_n) begin
            r_rd_en      <= 1'b0;
            r_flush      <= 1'b0;
            r_out_vsync  <= 1'b0;
            r_out_href   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_en      <= (w_state_nxt == ST_BURST);
            r_flush      <= w_abort;
            r_out_vsync  <= (r_state == ST_VSYNC);
            r_out_href   <= r_rd_en;   // FIFO read data arrives one cycle later
            r_frame_done <= w_done_nxt;
        end
    end

    assign rd_en      = r_rd_en;
    assign fifo_flush = r_flush;
    assign out_vsync  = r_out_vsync;
    assign out_href   = r_out_href;
    assign frame_done = r_frame_done;

    // ------------------------------------------------------------------
    // Dropped-pixel detection
    // ------------------------------------------------------------------
`ifdef DSAMP_SCHED_OVF_EN
    logic r_ovf;

    always_ff @(posedge dsamp_clk or negedge dsamp_rst_n) begin
        if (!dsamp_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_vsync_rise) begin
            r_ovf <= 1'b0;
        end else if (in_href & w_keep & fifo_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf_err = r_ovf;
`else
    assign ovf_err = 1'b0;
`endif

endmodule

`default_nettype wire
